// File: rtl/frame_decoder.sv
// ----------------------------------------------------------------------------
// frame_decoder
//
// Serial receiver and checker for 8-bit majority-coded frames. Bits arrive
// MSB first, one per accepted cycle. Bit 4 of each frame is the info bit,
// and the other 7 bits are data. When the frame is complete, the decoder
// recomputes the info bit from the data bits and the latched polarity. It
// then presents the data and a mismatch flag on a valid/ready output port.
// Two saturating counters track decoded frames and errored frames.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   control    polarity select, latched with the first bit of each frame
//   in_bit     serial frame bit (bit 7 first)
//   in_valid   in_bit is valid this cycle
//   in_ready   decoder accepts in_bit this cycle (registered, no out_ready path)
//   data_out   decoded data {w[7:5], w[3:0]}
//   err        received info bit differs from recomputed info bit
//   out_valid  data_out/err hold a decoded frame
//   out_ready  sink accepts the buffered frame
//   frame_cnt  frames decoded, saturating
//   err_cnt    frames decoded with err=1, saturating
// ----------------------------------------------------------------------------
module frame_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             control,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [6:0]       data_out,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // The frame position is the bit counter itself.
    // The named states only make the decode readable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LAST  = 2'd2
    } state_t;

    logic [7:0]       sr_reg;
    logic [2:0]       bit_cnt_reg;
    logic [2:0]       bit_cnt_next;
    logic             pol_reg;
    logic [6:0]       data_reg;
    logic             err_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;

    state_t           state;
    logic             accept;
    logic             complete;
    logic [7:0]       word;
    logic [6:0]       data_bits;
    logic [2:0]       ones_cnt;
    logic             maj0;
    logic             info_exp;
    logic             err_next;

    // ------------------------------------------------------------------
    // State register: the bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_reg <= 3'd0;
        end else begin
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: advance on every accept, wrapping 7 -> 0
    // ------------------------------------------------------------------
    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        if (accept) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        state = SHIFT;
        if (bit_cnt_reg == 3'd0) begin
            state = IDLE;
        end else if (bit_cnt_reg == 3'd7) begin
            state = LAST;
        end
        // Only the final bit waits for the buffer, so the next frame can
        // stream in while the previous one is still held.
        in_ready = !((state == LAST) && out_valid_reg);
        accept   = in_valid && in_ready;
        complete = accept && (state == LAST);
    end

    // ------------------------------------------------------------------
    // Frame check on the completing bit
    // ------------------------------------------------------------------
    assign word      = {sr_reg[6:0], in_bit};
    assign data_bits = {word[7:5], word[3:0]};

    always_comb begin
        ones_cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            ones_cnt = ones_cnt + {2'd0, data_bits[i]};
        end
        // With 7 bits a tie cannot happen, so zeros > ones means ones <= 3.
        maj0     = (ones_cnt <= 3'd3);
        info_exp = pol_reg ? !maj0 : maj0;
        err_next = (word[4] != info_exp);
    end

    // ------------------------------------------------------------------
    // Datapath, output buffer and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_reg        <= 8'd0;
            pol_reg       <= 1'b0;
            data_reg      <= 7'd0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else begin
            if (accept) begin
                sr_reg <= word;
                if (state == IDLE) begin
                    pol_reg <= control;
                end
            end
            // Completion requires an empty buffer, so it never collides with
            // a handshake on the same edge.
            if (complete) begin
                data_reg      <= data_bits;
                err_reg       <= err_next;
                out_valid_reg <= 1'b1;
                if (frame_cnt_reg != '1) begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
                if (err_next && (err_cnt_reg != '1)) begin
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                end
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign data_out  = data_reg;
    assign err       = err_reg;
    assign out_valid = out_valid_reg;
    assign frame_cnt = frame_cnt_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_frame_decoder.sv
// ----------------------------------------------------------------------------
// Testbench for frame_decoder. A reference model collects accepted bits into
// whole frames and decodes each frame with plain arithmetic. A monitor
// compares every output handshake against the model's queue.
// ----------------------------------------------------------------------------
module tb_frame_decoder;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             control = 1'b0;
    logic             in_bit = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       data_out;
    logic             err;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    frame_decoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .control   (control),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    bit [7:0] exp_q[$];       // {err, data[6:0]} per completed frame
    int       model_nbits  = 0;
    bit [7:0] model_sr     = 8'd0;
    bit       model_pol    = 1'b0;
    int       exp_fcnt     = 0;
    int       exp_ecnt     = 0;
    bit       rand_ready   = 1'b0;
    int       stall_cycles = 0;

    function automatic bit [7:0] ref_decode(input bit [7:0] w, input bit pol);
        bit [6:0] d;
        int       ones;
        bit       maj0;
        bit       info;
        d    = {w[7:5], w[3:0]};
        ones = 0;
        for (int i = 0; i < 7; i++) ones += int'(d[i]);
        maj0 = ((7 - ones) > ones);
        info = pol ? !maj0 : maj0;
        return {(w[4] != info), d};
    endfunction

    task automatic model_accept(input bit b, input bit ctl);
        bit [7:0] r;
        if (model_nbits == 0) model_pol = ctl;
        model_sr = {model_sr[6:0], b};
        model_nbits++;
        if (model_nbits == 8) begin
            r = ref_decode(model_sr, model_pol);
            exp_q.push_back(r);
            if (exp_fcnt < CMAX) exp_fcnt++;
            if (r[7] && exp_ecnt < CMAX) exp_ecnt++;
            model_nbits = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_nbits = 0;
        model_sr    = 8'd0;
        exp_fcnt    = 0;
        exp_ecnt    = 0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change at posedge+1 and are sampled at negedge.
    // ------------------------------------------------------------------
    task automatic drive_bit(input bit b, input bit ctl);
        int waited = 0;
        bit done = 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        control  = ctl;
        while (!done) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                model_accept(b, ctl);
                done = 1'b1;
            end else begin
                stall_cycles++;
                waited++;
                if (waited > 100) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL accept_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input bit [7:0] f, input bit ctl);
        for (int i = 7; i >= 0; i--) drive_bit(f[i], ctl);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Output monitor: scoreboard plus hold-stability check under backpressure
    // ------------------------------------------------------------------
    bit       hold_valid = 1'b0;
    bit [7:0] hold_val   = 8'd0;
    bit [7:0] exp_out;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                hold_valid = 1'b0;
            end else if (out_valid === 1'b1) begin
                if (hold_valid) begin
                    tests_run++;
                    if ({err, data_out} !== hold_val) begin
                        tests_failed++;
                        $display("FAIL output_stable: got %h, required %h", {err, data_out}, hold_val);
                    end
                end
                if (out_ready === 1'b1) begin
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL unexpected_output: got %h, required no frame", {err, data_out});
                    end else begin
                        exp_out = exp_q.pop_front();
                        if ({err, data_out} !== exp_out) begin
                            tests_failed++;
                            $display("FAIL frame_output: got err=%b data=%h, required err=%b data=%h",
                                     err, data_out, exp_out[7], exp_out[6:0]);
                        end
                    end
                    hold_valid = 1'b0;
                end else begin
                    hold_valid = 1'b1;
                    hold_val   = {err, data_out};
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic check_counters(input string name);
        tests_run++;
        if (frame_cnt !== CNT_W'(exp_fcnt) || err_cnt !== CNT_W'(exp_ecnt)) begin
            tests_failed++;
            $display("FAIL %s_counters: got frame_cnt=%0d err_cnt=%0d, required %0d %0d",
                     name, frame_cnt, err_cnt, exp_fcnt, exp_ecnt);
        end
    endtask

    task automatic check_drained(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: got %0d frames pending, required 0", name, exp_q.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        tests_run++;
        if ({out_valid, err, data_out, frame_cnt, err_cnt, in_ready} !== {1'b0, 1'b0, 7'd0, 8'd0, 8'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b e=%b d=%h fc=%0d ec=%0d rdy=%b, required 0 0 00 0 0 1",
                     out_valid, err, data_out, frame_cnt, err_cnt, in_ready);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        bit [7:0] f = 8'hA3;
        do_reset();
        out_ready = 1'b1;
        for (int i = 7; i >= 1; i--) drive_bit(f[i], 1'b0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_early_valid: got out_valid=%b, required 0", out_valid);
        end
        drive_bit(f[0], 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || data_out !== 7'h53 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_A3: got v=%b d=%h e=%b, required 1 53 0", out_valid, data_out, err);
        end
        tests_run++;
        if (frame_cnt !== 8'd1 || err_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL basic_counts: got fc=%0d ec=%0d, required 1 0", frame_cnt, err_cnt);
        end
        idle(3);
        check_drained("basic");
        $display("[TB] test_basic frame=A3 data=%h err=%b", data_out, err);
    endtask

    task automatic test_polarity_select();
        do_reset();
        out_ready = 1'b1;
        send_frame(8'hB3, 1'b1);
        tests_run++;
        if (data_out !== 7'h53 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL pol1_B3: got d=%h e=%b, required 53 0", data_out, err);
        end
        send_frame(8'hB3, 1'b0);
        tests_run++;
        if (data_out !== 7'h53 || err !== 1'b1 || err_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL pol0_B3: got d=%h e=%b ec=%0d, required 53 1 1", data_out, err, err_cnt);
        end
        idle(3);
        check_counters("polarity");
        check_drained("polarity");
        $display("[TB] test_polarity_select done");
    endtask

    task automatic test_corrupt();
        do_reset();
        out_ready = 1'b1;
        send_frame(8'hA2, 1'b0);
        tests_run++;
        if (data_out !== 7'h52 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL corrupt_A2: got d=%h e=%b, required 52 1", data_out, err);
        end
        idle(3);
        check_drained("corrupt");
        $display("[TB] test_corrupt frame=A2 data=%h err=%b", data_out, err);
    endtask

    task automatic test_polarity_latch();
        bit [7:0] f = 8'hA3;
        do_reset();
        out_ready = 1'b1;
        // control starts at 0 on bit 7, then toggles every bit
        for (int i = 7; i >= 0; i--) drive_bit(f[i], 1'((7 - i) % 2));
        tests_run++;
        if (err !== 1'b0 || data_out !== 7'h53) begin
            tests_failed++;
            $display("FAIL polarity_latch: got d=%h e=%b, required 53 0", data_out, err);
        end
        idle(3);
        check_drained("latch");
        $display("[TB] test_polarity_latch done");
    endtask

    task automatic test_backpressure();
        bit [7:0] f = 8'hB3;
        do_reset();
        out_ready = 1'b0;
        send_frame(8'hA3, 1'b0);
        for (int i = 7; i >= 1; i--) drive_bit(f[i], 1'b1);
        in_valid = 1'b1;
        in_bit   = f[0];
        control  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== 7'h53) begin
                tests_failed++;
                $display("FAIL backpressure_stall: got rdy=%b v=%b d=%h, required 0 1 53",
                         in_ready, out_valid, data_out);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drive_bit(f[0], 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || data_out !== 7'h53 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_B3: got v=%b d=%h e=%b, required 1 53 0", out_valid, data_out, err);
        end
        // A following frame confirms the bit alignment survived the stall.
        send_frame(8'hA2, 1'b0);
        idle(3);
        check_counters("backpressure");
        check_drained("backpressure");
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_reset_midframe();
        bit [7:0] f = 8'hB3;
        do_reset();
        out_ready = 1'b0;
        send_frame(8'hA3, 1'b0);
        for (int i = 7; i >= 4; i--) drive_bit(f[i], 1'b1);
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0 || frame_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got v=%b fc=%0d, required 0 0", out_valid, frame_cnt);
        end
        out_ready = 1'b1;
        send_frame(8'hA3, 1'b0);
        tests_run++;
        if (data_out !== 7'h53 || frame_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL midreset_frame: got d=%h fc=%0d, required 53 1", data_out, frame_cnt);
        end
        idle(3);
        check_drained("midreset");
        $display("[TB] test_reset_midframe done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready    = 1'b1;
        stall_cycles = 0;
        for (int n = 0; n < 4; n++) send_frame(8'($urandom), 1'($urandom_range(0, 1)));
        idle(3);
        tests_run++;
        if (stall_cycles != 0) begin
            tests_failed++;
            $display("FAIL back_to_back_stalls: got %0d stalls, required 0", stall_cycles);
        end
        check_counters("back_to_back");
        check_drained("back_to_back");
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_random();
        bit [7:0] f;
        do_reset();
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            f = 8'($urandom);
            for (int i = 7; i >= 0; i--) drive_bit(f[i], 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle(4);
        check_counters("random");
        check_drained("random");
        $display("[TB] test_random 40 frames done");
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 256; n++) send_frame(8'hA2, 1'b0);
        idle(3);
        tests_run++;
        if (err_cnt !== 8'd255 || frame_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL saturation: got fc=%0d ec=%0d, required 255 255", frame_cnt, err_cnt);
        end
        check_counters("saturation");
        check_drained("saturation");
        $display("[TB] test_saturation done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_polarity_select();
        test_corrupt();
        test_polarity_latch();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frame_decoder.md
# frame_decoder

Serial receiver and checker for the 8-bit majority-coded frame our encoder produces. It deserializes one bit per accepted cycle, strips the info bit at position 4, and recomputes the expected info bit from the 7 data bits. It presents the data and an error flag on a valid/ready output port, and keeps saturating frame and error counters for the test environment.

## Interface
Parameters:
- CNT_W, 8, width of frame_cnt and err_cnt

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- control  input  1  polarity select. 0: info=1 when zeros>ones. 1: info=1 when ones>zeros. Sampled with a frame's first bit.
- in_bit  input  1  serial frame bit, MSB (bit 7) first
- in_valid  input  1  in_bit valid this cycle
- in_ready  output  1  decoder accepts in_bit this cycle
- data_out  output  7  decoded data {w[7:5], w[3:0]}
- err  output  1  received info bit differs from recomputed info bit
- out_valid  output  1  data_out/err hold a decoded frame
- out_ready  input  1  sink accepts the frame
- frame_cnt  output  CNT_W  frames decoded, saturating
- err_cnt  output  CNT_W  frames with err=1, saturating

## Operation
- Registers:
  - shift register sr[7:0]
  - bit counter bit_cnt[2:0]
  - latched polarity pol
  - output buffer: data_out, err, out_valid
  - frame_cnt, err_cnt
- Accept: a bit is taken when in_valid && in_ready. Each accept does sr <= {sr[6:0], in_bit} and bit_cnt <= bit_cnt+1, wrapping 7->0.
- Polarity: pol is loaded from control on the accept with bit_cnt==0. Changes to control mid-frame are ignored.
- States, implied by bit_cnt:
  - IDLE: bit_cnt==0
  - SHIFT: bit_cnt 1..6
  - LAST: bit_cnt==7
- Completion: an accept in LAST completes a frame. Let w = {sr[6:0], in_bit}.
  - Count the ones in the 7 data bits. A tie is impossible.
  - maj0 = (zeros > ones).
  - Expected info: maj0 if pol==0, else !maj0.
  - err = (w[4] != expected).
- Completion loads the output buffer with data_out = {w[7:5], w[3:0]} and err. It sets out_valid=1, increments frame_cnt, and increments err_cnt if err. Both counters stop at 2^CNT_W-1.
- Output handshake: out_valid && out_ready clears out_valid. data_out/err stay stable while out_valid=1 && out_ready=0.
- Backpressure: in_ready = !(bit_cnt==7 && out_valid). It is a function of registers only, with no combinational path from out_ready.
  - Bits 0..6 of the next frame are accepted while the previous frame is still buffered.
  - The final bit stalls until the buffer is empty.
- No in_valid: the state holds, with no timeout.

## Timing
- Reset (rst_n=0 at a clk edge):
  - sr=0, bit_cnt=0, pol=0
  - data_out=0, err=0, out_valid=0
  - frame_cnt=0, err_cnt=0
  - in_ready=1 from the next cycle
- Reset mid-frame discards the partial frame and any buffered output, with no counter update.
- Latency: final bit accepted on edge N; out_valid=1 with valid data_out/err after edge N, i.e. in cycle N+1.
- Throughput: one frame per 8 accepts. With out_ready held 1, in_ready stays 1 continuously.
- Output handshake completing on edge N while bit_cnt==7 and in_valid=1: in_ready rises in cycle N+1, the bit is accepted at edge N+1, and out_valid reasserts in cycle N+2.
- Counters update on the same edge that sets out_valid.
- Counter saturation: at 2^CNT_W-1 the counter holds. It never wraps to 0.

## Test plan
- Reset, then frame 0xA3 with control=0 and out_ready=1 -> data_out=0x53, err=0, frame_cnt=1, err_cnt=0; out_valid one cycle after the 8th bit.
- Frame 0xB3 with control=1 -> data_out=0x53, err=0. Same 0xB3 with control=0 -> err=1, err_cnt=1.
- Data-bit corruption: 0xA2 with control=0 (data 0x52, ones=3, expected info 1) -> err=1, data_out=0x52.
- Backpressure: out_ready=0, send 0xA3 then 0xB3 (control=1) continuously -> in_ready=0 at the 0xB3 final bit and data_out stays 0x53. Raise out_ready -> 0xB3 completes with err=0, and no bit is lost or duplicated.
- Polarity latch: toggle control after bit 7 of frame 0xA3 started with control=0 -> err=0.
- Reset after 4 bits, then full frame 0xA3 -> single output 0x53 with frame_cnt=1. Counter saturation: 256 error frames with CNT_W=8 -> err_cnt stays at 255.
